// File: rtl/hv_piso.sv
// Serial output stage for the HV channel enable word: shifts a parallel word MSB-first
// into an external SIPO driver chain, then strobes its latch. Optional refresh: HV_PISO_REFRESH_EN.
module hv_piso #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned CLK_DIV        = 10,
    parameter int unsigned REFRESH_PERIOD = 1000000
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             sdo,
    output logic             lock
);

    localparam int unsigned BIT_W = $clog2(WIDTH + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_HIGH    = 3'd2;
    localparam logic [2:0] S_LOCK_HI = 3'd3;
    localparam logic [2:0] S_LOCK_LO = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [WIDTH-1:0] pend_reg, pend_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             busy_nxt, done_nxt, sclk_nxt, sdo_nxt, lock_nxt;
    logic             div_last;
    logic             start;
    logic [WIDTH-1:0] start_word;

`ifdef HV_PISO_REFRESH_EN
    localparam int unsigned REF_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    logic [WIDTH-1:0] last_word, last_nxt;
    logic [REF_W-1:0] ref_cnt, ref_nxt;
`endif

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt    = state;
        div_nxt      = div_cnt;
        bit_nxt      = bit_cnt;
        shift_nxt    = shift_reg;
        pend_nxt     = pend_reg;
        pend_vld_nxt = pend_vld;
        start        = 1'b0;
        start_word   = data;
        div_last     = (div_cnt == DIV_W'(CLK_DIV - 1));

        // Any write during a frame is parked; latest write wins
        if (state != S_IDLE && wrreq) begin
            pend_nxt     = data;
            pend_vld_nxt = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (wrreq) begin
                    start = 1'b1;
`ifdef HV_PISO_REFRESH_EN
                end else if (ref_cnt == REF_W'(REFRESH_PERIOD - 1)) begin
                    start      = 1'b1;
                    start_word = last_word;
`endif
                end
            end
            S_SETUP: begin
                if (div_last) begin
                    state_nxt = S_HIGH;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (div_last) begin
                    div_nxt   = '0;
                    shift_nxt = shift_reg << 1;
                    bit_nxt   = bit_cnt + BIT_W'(1);
                    state_nxt = (bit_cnt == BIT_W'(WIDTH - 1)) ? S_LOCK_HI : S_SETUP;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            S_LOCK_HI: begin
                if (div_last) begin
                    state_nxt = S_LOCK_LO;
                    div_nxt   = '0;
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            S_LOCK_LO: begin
                if (div_last) begin
                    // A write on the done cycle is newer than anything parked
                    if (wrreq) begin
                        start = 1'b1;
                    end else if (pend_vld) begin
                        start      = 1'b1;
                        start_word = pend_reg;
                    end else begin
                        state_nxt = S_IDLE;
                        div_nxt   = '0;
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                div_nxt   = '0;
            end
        endcase

        if (start) begin
            state_nxt    = S_SETUP;
            div_nxt      = '0;
            bit_nxt      = '0;
            shift_nxt    = start_word;
            pend_vld_nxt = 1'b0;
        end

`ifdef HV_PISO_REFRESH_EN
        last_nxt = start ? start_word : last_word;
        ref_nxt  = (state == S_IDLE && state_nxt == S_IDLE) ? ref_cnt + REF_W'(1) : '0;
`endif

        busy_nxt = (state_nxt != S_IDLE);
        sclk_nxt = (state_nxt == S_HIGH);
        sdo_nxt  = (state_nxt == S_SETUP || state_nxt == S_HIGH) ? shift_nxt[WIDTH-1] : 1'b0;
        lock_nxt = (state_nxt == S_LOCK_HI);
        done_nxt = (state_nxt == S_LOCK_LO) && (div_nxt == DIV_W'(CLK_DIV - 1));
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            pend_reg  <= '0;
            pend_vld  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            sdo       <= 1'b0;
            lock      <= 1'b0;
`ifdef HV_PISO_REFRESH_EN
            last_word <= '0;
            ref_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            pend_reg  <= pend_nxt;
            pend_vld  <= pend_vld_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            sclk      <= sclk_nxt;
            sdo       <= sdo_nxt;
            lock      <= lock_nxt;
`ifdef HV_PISO_REFRESH_EN
            last_word <= last_nxt;
            ref_cnt   <= ref_nxt;
`endif
        end
    end

endmodule

// File: doc/hv_piso.md
# hv_piso

Serial output stage for the HV channel enable word. Accepts a WIDTH-bit parallel word with a single-cycle write strobe and shifts it MSB-first into an external serial-in/parallel-out driver chain (shift clock, data, latch), then pulses the latch so all HV enables update together. Sits directly downstream of the HV/PWM register block, which feeds it the registered enable word and write strobe. Supports back-to-back updates via a one-deep pending register, and an optional periodic refresh.

## Interface
- WIDTH, 8: number of enable bits shifted per frame (1..32).
- CLK_DIV, 10: clk cycles per sclk half-period (>= 1).
- REFRESH_PERIOD, 1000000: idle clk cycles before auto-retransmit; used only with refresh compiled in.

- clk  in  1  system clock; all logic on rising edge.
- aclr  in  1  reset, asynchronous, active-high.
- data  in  WIDTH  enable word; sampled only in a cycle where wrreq=1.
- wrreq  in  1  write strobe, one cycle per word; accepted in every cycle.
- busy  out  1  high from the cycle after frame start until the cycle after done.
- done  out  1  one-cycle pulse on the last cycle of each frame.
- sclk  out  1  shift clock to the external chain; receiver samples sdo on its rising edge.
- sdo  out  1  serial data, MSB first.
- lock  out  1  latch strobe to the external chain, high for CLK_DIV cycles per frame.

## Operation
- Registers: shift reg (WIDTH), last-word reg (WIDTH), pending reg (WIDTH) plus pending flag, bit counter (clog2(WIDTH+1)), divider counter (clog2(CLK_DIV+1)), state.
- Reset values: busy=0, done=0, sclk=0, sdo=0, lock=0; all registers 0, pending flag 0, state IDLE.
- States: IDLE -> SETUP -> HIGH -> (SETUP for next bit | LOCK_HI after bit WIDTH-1) -> LOCK_LO -> IDLE or SETUP.
- IDLE: wrreq=1 loads data into shift reg and last-word reg, goes to SETUP.
- SETUP: sclk=0, sdo=shift[MSB]; lasts CLK_DIV cycles, then HIGH.
- HIGH: sclk=1, sdo unchanged; lasts CLK_DIV cycles; on exit shift reg shifts left by 1, bit counter increments.
- LOCK_HI: sclk=0, sdo=0, lock=1 for CLK_DIV cycles.
- LOCK_LO: lock=0 for CLK_DIV cycles; done=1 on its last cycle.
- wrreq while state != IDLE (including the done cycle): data goes into the pending reg, flag set; a later wrreq overwrites it (latest wins). It never disturbs the frame in flight.
- End of LOCK_LO with flag set: pending word loads into shift and last-word regs, flag clears, next state SETUP. busy stays high, with no idle gap.
- aclr mid-frame: immediate abort to reset values. No lock pulse is issued, so the external chain keeps its previously latched outputs.

## Timing
- wrreq sampled at cycle 0 in IDLE. At cycle 1: busy=1, sdo=data[WIDTH-1].
- Bit i: SETUP starts at cycle 1+2*i*CLK_DIV; sclk rises at cycle 1+(2*i+1)*CLK_DIV.
- lock high during cycles 1+2*WIDTH*CLK_DIV .. (2*WIDTH+1)*CLK_DIV.
- done at cycle (2*WIDTH+2)*CLK_DIV. busy=0 at the next cycle, unless a pending word exists.
- Frame length is (2*WIDTH+2)*CLK_DIV cycles. WIDTH=8, CLK_DIV=10 gives 180 cycles.
- CLK_DIV=1: sclk toggles every cycle (clk/2).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- HV_PISO_REFRESH_EN defined: a refresh counter counts cycles spent in IDLE and clears on any frame start. When it reaches REFRESH_PERIOD-1 in IDLE with no wrreq, the last-word reg is retransmitted as a normal frame (busy, done and lock behave identically). A wrreq in the same cycle takes priority and clears the counter. This recovers from upsets in the external chain.
- Not defined: no refresh counter is built, frames start only on wrreq, and REFRESH_PERIOD is ignored.

## Test plan
- Reset, WIDTH=8, CLK_DIV=10, data=8'hA5 with wrreq at cycle 0 -> sdo at the 8 sclk rises reads 1,0,1,0,0,1,0,1; first rise at cycle 11; lock high cycles 161–170; done at 180; busy low at 181.
- wrreq 8'h3C at cycle 0, then 8'h11 at cycle 50 and 8'hC3 at cycle 60 -> frame 1 shifts 3C, frame 2 starts SETUP at cycle 181 and shifts C3; 11 is never sent; busy is continuously high through cycle 360.
- wrreq 8'hFF, aclr asserted at cycle 70 for 3 cycles -> all outputs 0 within the reset; no lock pulse; a following wrreq 8'h01 runs a clean full frame.
- CLK_DIV=1, data=8'h80 -> sclk period 2 cycles; frame 18 cycles; done at cycle 18.
- HV_PISO_REFRESH_EN, REFRESH_PERIOD=100, one wrreq 8'h5A -> an identical 8'h5A frame restarts after 100 idle cycles and repeats. A wrreq 8'h0F on the 100th idle cycle sends 0F instead.
- wrreq on the exact done cycle of a frame -> new word is queued and sent back-to-back; busy never drops.
